// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wr_arbiter
// Purpose  : Round-robin, grant-locked burst arbiter that shares the byte
//            write port of the 8-in/16-out packing FIFO between two producers.
//            Bursts are even-length, so a packed 16-bit word never mixes
//            bytes from both sources.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter #(
    parameter int DATA_W    = 8,
    parameter int BURST_LEN = 2,
    parameter int CNT_W     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              src0_valid,
    input  logic [DATA_W-1:0] src0_data,
    output logic              src0_enable,
    input  logic              src1_valid,
    input  logic [DATA_W-1:0] src1_data,
    output logic              src1_enable,
    output logic              fifo_valid,
    output logic [DATA_W-1:0] fifo_data,
    input  logic              fifo_enable,
    output logic [1:0]        grant,
    output logic              busy,
    output logic              burst_done
);

    localparam logic [0:0]       c_IDLE      = 1'b0;
    localparam logic [0:0]       c_BURST     = 1'b1;
    localparam logic [CNT_W-1:0] c_LAST_BEAT = CNT_W'(BURST_LEN - 1);
    localparam logic [CNT_W-1:0] c_ONE       = CNT_W'(1);

    logic [0:0]       r_state;
    logic             r_owner;
    logic             r_last_owner;
    logic [CNT_W-1:0] r_beat;
    logic             r_burst_done;

    logic [0:0]       w_state_nxt;
    logic             w_owner_nxt;
    logic             w_last_owner_nxt;
    logic [CNT_W-1:0] w_beat_nxt;
    logic             w_burst_done_nxt;

    logic             w_owner_valid;
    logic             w_beat_evt;

    // Owner's request and the write event shared with the FIFO.
    assign w_owner_valid = r_owner ? src1_valid : src0_valid;
    assign w_beat_evt    = (r_state == c_BURST) && w_owner_valid && fifo_enable;

    // State register: async reset abandons any burst in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_IDLE;
            r_owner      <= 1'b0;
            r_last_owner <= 1'b1;   // src0 wins the first tie
            r_beat       <= '0;
            r_burst_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_owner      <= w_owner_nxt;
            r_last_owner <= w_last_owner_nxt;
            r_beat       <= w_beat_nxt;
            r_burst_done <= w_burst_done_nxt;
        end
    end

    // Next state: arbitrate in IDLE, count beats in BURST, no preemption.
    always_comb begin
        w_state_nxt      = r_state;
        w_owner_nxt      = r_owner;
        w_last_owner_nxt = r_last_owner;
        w_beat_nxt       = r_beat;
        w_burst_done_nxt = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (src0_valid && src1_valid) begin
                    w_state_nxt = c_BURST;
                    w_owner_nxt = ~r_last_owner;
                    w_beat_nxt  = '0;
                end else if (src0_valid) begin
                    w_state_nxt = c_BURST;
                    w_owner_nxt = 1'b0;
                    w_beat_nxt  = '0;
                end else if (src1_valid) begin
                    w_state_nxt = c_BURST;
                    w_owner_nxt = 1'b1;
                    w_beat_nxt  = '0;
                end
            end
            c_BURST: begin
                if (w_beat_evt) begin
                    if (r_beat == c_LAST_BEAT) begin
                        w_state_nxt      = c_IDLE;
                        w_last_owner_nxt = r_owner;
                        w_beat_nxt       = '0;
                        w_burst_done_nxt = 1'b1;
                    end else begin
                        w_beat_nxt = r_beat + c_ONE;
                    end
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // Outputs: steer the owner's byte to the FIFO; enables follow fifo_enable
    // only, never the sources' valids, so no combinational loop can form.
    always_comb begin
        fifo_valid  = 1'b0;
        fifo_data   = '0;
        src0_enable = 1'b0;
        src1_enable = 1'b0;
        grant       = 2'b00;
        busy        = 1'b0;
        if (r_state == c_BURST) begin
            busy       = 1'b1;
            fifo_valid = w_owner_valid;
            if (r_owner) begin
                fifo_data   = src1_data;
                src1_enable = fifo_enable;
                grant       = 2'b10;
            end else begin
                fifo_data   = src0_data;
                src0_enable = fifo_enable;
                grant       = 2'b01;
            end
        end
    end

    assign burst_done = r_burst_done;

endmodule
`default_nettype wire
